// File: rtl/mmio_tpu_bridge.sv
// Queues in-window host MMIO reads/writes and replays them to the TPU one op at a time.
// Optional traffic counters are enabled with `define MMIO_BRIDGE_STATS_EN.
module mmio_tpu_bridge #(
  parameter int          DEPTH    = 8,
  parameter int          RD_LAT   = 1,
  parameter logic [7:0]  WIN_BASE = 8'h03
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mmio_wr_valid,
  input  logic        mmio_rd_valid,
  input  logic [15:0] mmio_addr,
  input  logic [63:0] mmio_wdata,
  input  logic [8:0]  mmio_tid,
  output logic        tpu_r_w,
  output logic [15:0] tpu_addr,
  output logic [63:0] tpu_din,
  input  logic [63:0] tpu_dout,
  output logic        rsp_valid,
  output logic [8:0]  rsp_tid,
  output logic [63:0] rsp_data,
  output logic        busy,
  output logic        ovf_sticky,
`ifdef MMIO_BRIDGE_STATS_EN
  input  logic        stat_clr,
  output logic [31:0] stat_wr_cnt,
  output logic [31:0] stat_rd_cnt,
  output logic [31:0] stat_drop_cnt,
`endif
  input  logic        ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic        is_rd;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [8:0]  tid;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_RESP} state_t;

  entry_t        fifo_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  state_t        state_q, state_d;
  logic          cur_rd_q, cur_rd_d;
  logic [8:0]    cur_tid_q, cur_tid_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          tpu_r_w_q, tpu_r_w_d;
  logic [15:0]   tpu_addr_q, tpu_addr_d;
  logic [63:0]   tpu_din_q, tpu_din_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [8:0]    rsp_tid_q, rsp_tid_d;
  logic [63:0]   rsp_data_q, rsp_data_d;
  logic          ovf_q, ovf_d;

  logic   in_win, wr_req, rd_req, full, push, pop;
  logic [1:0] drop_n;
  entry_t push_entry, head;

  always_comb begin
    in_win = (mmio_addr[15:8] == WIN_BASE);
    wr_req = mmio_wr_valid & in_win;
    rd_req = mmio_rd_valid & in_win;
    full   = (count_q == FULL_CNT);
    push   = (wr_req | rd_req) & ~full;
    // A write wins over a simultaneous read; the read counts as a drop.
    if (full) drop_n = {1'b0, wr_req} + {1'b0, rd_req};
    else      drop_n = {1'b0, wr_req & rd_req};
    push_entry = '{is_rd: ~wr_req, addr: mmio_addr, wdata: mmio_wdata, tid: mmio_tid};
    head = fifo_mem_q[rd_ptr_q];
    pop  = (state_q == S_IDLE) && (count_q != '0);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    ovf_d    = (drop_n != 2'd0) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_comb begin
    state_d     = state_q;
    cur_rd_d    = cur_rd_q;
    cur_tid_d   = cur_tid_q;
    wait_d      = wait_q;
    tpu_r_w_d   = 1'b0;
    tpu_addr_d  = tpu_addr_q;
    tpu_din_d   = tpu_din_q;
    rsp_valid_d = 1'b0;
    rsp_tid_d   = rsp_tid_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          cur_rd_d   = head.is_rd;
          cur_tid_d  = head.tid;
          tpu_addr_d = head.addr;
          if (!head.is_rd) tpu_din_d = head.wdata;
          tpu_r_w_d  = ~head.is_rd;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cur_rd_q) begin
          wait_d  = CW'(RD_LAT - 1);
          state_d = S_WAIT_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_RD: begin
        if (wait_q == '0) begin
          rsp_data_d  = tpu_dout;
          rsp_tid_d   = cur_tid_q;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      cur_rd_q    <= 1'b0;
      cur_tid_q   <= '0;
      wait_q      <= '0;
      tpu_r_w_q   <= 1'b0;
      tpu_addr_q  <= '0;
      tpu_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cur_rd_q    <= cur_rd_d;
      cur_tid_q   <= cur_tid_d;
      wait_q      <= wait_d;
      tpu_r_w_q   <= tpu_r_w_d;
      tpu_addr_q  <= tpu_addr_d;
      tpu_din_q   <= tpu_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tid_q   <= rsp_tid_d;
      rsp_data_q  <= rsp_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign tpu_r_w    = tpu_r_w_q;
  assign tpu_addr   = tpu_addr_q;
  assign tpu_din    = tpu_din_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_tid    = rsp_tid_q;
  assign rsp_data   = rsp_data_q;
  assign ovf_sticky = ovf_q;
  assign busy       = (count_q != '0) || (state_q != S_IDLE);

`ifdef MMIO_BRIDGE_STATS_EN
  logic [31:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, drop_cnt_q, drop_cnt_d;
  logic        issue_wr, issue_rd;

  always_comb begin
    issue_wr = (state_q == S_ISSUE) && !cur_rd_q;
    issue_rd = (state_q == S_ISSUE) && cur_rd_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (issue_wr && wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_d = wr_cnt_q + 32'd1;
    if (issue_rd && rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_d = rd_cnt_q + 32'd1;
    if (drop_cnt_q > 32'hFFFF_FFFF - {30'd0, drop_n}) drop_cnt_d = 32'hFFFF_FFFF;
    else                                               drop_cnt_d = drop_cnt_q + {30'd0, drop_n};
    if (stat_clr) begin
      wr_cnt_d   = '0;
      rd_cnt_d   = '0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign stat_wr_cnt   = wr_cnt_q;
  assign stat_rd_cnt   = rd_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_mmio_tpu_bridge.sv
// Directed bench for mmio_tpu_bridge: a vector table plus hand-written latency, overflow and
// reset sequences. A second instance with RD_LAT=4 is used for the mid-read reset case.
module tb_mmio_tpu_bridge;
  logic        clk = 1'b0;
  logic        rst_n, mmio_wr_valid, mmio_rd_valid, ovf_clr;
  logic [15:0] mmio_addr;
  logic [63:0] mmio_wdata;
  logic [8:0]  mmio_tid;

  logic        tpu_r_w, rsp_valid, busy, ovf_sticky;
  logic [15:0] tpu_addr;
  logic [63:0] tpu_din, tpu_dout, rsp_data;
  logic [8:0]  rsp_tid;

  logic        tpu_r_w4, rsp_valid4, busy4, ovf_sticky4;
  logic [15:0] tpu_addr4;
  logic [63:0] tpu_din4, rsp_data4;
  logic [63:0] tpu_dout4 = 64'hCAFE_F00D_0000_0001;
  logic [8:0]  rsp_tid4;

`ifdef MMIO_BRIDGE_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_wr_cnt, stat_rd_cnt, stat_drop_cnt;
  logic [31:0] stat_wr_cnt4, stat_rd_cnt4, stat_drop_cnt4;
`endif

  always #5 clk = ~clk;

  mmio_tpu_bridge #(.DEPTH(8), .RD_LAT(1), .WIN_BASE(8'h03)) u_dut (
    .clk(clk), .rst_n(rst_n), .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_tid(mmio_tid),
    .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_din(tpu_din), .tpu_dout(tpu_dout),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data), .busy(busy),
    .ovf_sticky(ovf_sticky),
`ifdef MMIO_BRIDGE_STATS_EN
    .stat_clr(stat_clr), .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt),
    .stat_drop_cnt(stat_drop_cnt),
`endif
    .ovf_clr(ovf_clr));

  mmio_tpu_bridge #(.DEPTH(8), .RD_LAT(4), .WIN_BASE(8'h03)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_tid(mmio_tid),
    .tpu_r_w(tpu_r_w4), .tpu_addr(tpu_addr4), .tpu_din(tpu_din4), .tpu_dout(tpu_dout4),
    .rsp_valid(rsp_valid4), .rsp_tid(rsp_tid4), .rsp_data(rsp_data4), .busy(busy4),
    .ovf_sticky(ovf_sticky4),
`ifdef MMIO_BRIDGE_STATS_EN
    .stat_clr(stat_clr), .stat_wr_cnt(stat_wr_cnt4), .stat_rd_cnt(stat_rd_cnt4),
    .stat_drop_cnt(stat_drop_cnt4),
`endif
    .ovf_clr(ovf_clr));

  // TPU model for the RD_LAT=1 instance: registered read, one cycle after the address.
  logic [63:0] mem [0:255];
  always @(posedge clk) begin
    if (tpu_r_w) mem[tpu_addr[7:0]] <= tpu_din;
    tpu_dout <= mem[tpu_addr[7:0]];
  end

  int          n_wr = 0, n_rsp = 0, n_rsp4 = 0, n_busy = 0;
  logic [15:0] wlog_addr [$];
  logic [63:0] wlog_din  [$];
  logic [63:0] lr_data;
  logic [8:0]  lr_tid;
  always @(negedge clk) begin
    if (tpu_r_w) begin
      n_wr++;
      wlog_addr.push_back(tpu_addr);
      wlog_din.push_back(tpu_din);
    end
    if (rsp_valid) begin
      n_rsp++;
      lr_data = rsp_data;
      lr_tid  = rsp_tid;
    end
    if (busy) n_busy++;
    if (rsp_valid4) n_rsp4++;
  end

  int passed = 0, total = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic strobe(input bit wr, input bit rd, input logic [15:0] a, input logic [63:0] d,
                        input logic [8:0] t);
    mmio_wr_valid = wr; mmio_rd_valid = rd; mmio_addr = a; mmio_wdata = d; mmio_tid = t;
    cyc();
    mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0;
  endtask

  typedef struct {
    bit          wr, rd;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [8:0]  tid;
    int          e_nwr, e_nrsp;
    bit          e_busy, e_ovf;
    logic [15:0] e_addr;
    logic [63:0] e_data;
    logic [8:0]  e_tid;
  } vec_t;
  vec_t vecs [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bw, br, bb, bq, br4;
    vecs.push_back('{1, 0, 16'h0310, 64'hDEAD_BEEF, 9'h000, 1, 0, 1, 0, 16'h0310, 64'hDEAD_BEEF, 9'h000});
    vecs.push_back('{1, 0, 16'h0305, 64'h5,         9'h000, 1, 0, 1, 0, 16'h0305, 64'h5,         9'h000});
    vecs.push_back('{0, 1, 16'h0305, 64'h0,         9'h01A, 0, 1, 1, 0, 16'h0000, 64'h5,         9'h01A});
    vecs.push_back('{0, 1, 16'h0008, 64'h0,         9'h011, 0, 0, 0, 0, 16'h0000, 64'h0,         9'h000});
    vecs.push_back('{1, 0, 16'h0008, 64'h9,         9'h000, 0, 0, 0, 0, 16'h0000, 64'h0,         9'h000});
    vecs.push_back('{0, 1, 16'h0310, 64'h0,         9'h1FF, 0, 1, 1, 0, 16'h0000, 64'hDEAD_BEEF, 9'h1FF});
    vecs.push_back('{1, 1, 16'h0320, 64'h77,        9'h005, 1, 0, 1, 1, 16'h0320, 64'h77,        9'h000});
    vecs.push_back('{0, 1, 16'h0320, 64'h0,         9'h000, 0, 1, 1, 0, 16'h0000, 64'h77,        9'h000});
    vecs.push_back('{1, 1, 16'h0420, 64'h88,        9'h007, 0, 0, 0, 0, 16'h0000, 64'h0,         9'h000});

    rst_n = 1'b0; mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0; ovf_clr = 1'b0;
    mmio_addr = '0; mmio_wdata = '0; mmio_tid = '0;
`ifdef MMIO_BRIDGE_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_tpu_r_w", tpu_r_w, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ovf", ovf_sticky, 0);
    chk("rst_tpu_addr", tpu_addr, 0);
    chk("rst_rsp_data", rsp_data, 0);
    rst_n = 1'b1;
    cyc();

    // Write latency: strobe in cycle 0, pins driven and pulse in cycle 2.
    strobe(1, 0, 16'h0310, 64'hDEAD_BEEF, 9'h0);
    @(negedge clk);
    chk("lat_c1_r_w", tpu_r_w, 0);
    chk("lat_c1_busy", busy, 1);
    @(negedge clk);
    chk("lat_c2_r_w", tpu_r_w, 1);
    chk("lat_c2_addr", tpu_addr, 16'h0310);
    chk("lat_c2_din", tpu_din, 64'hDEAD_BEEF);
    @(negedge clk);
    chk("lat_c3_r_w", tpu_r_w, 0);
    chk("lat_c3_busy", busy, 0);
    cyc();

    // Read latency with RD_LAT=1: rsp_valid in cycle 4 only.
    strobe(0, 1, 16'h0310, 64'h0, 9'h003);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("rdlat_c%0d_valid", c), rsp_valid, (c == 4) ? 1 : 0);
      if (c == 4) begin
        chk("rdlat_data", rsp_data, 64'hDEAD_BEEF);
        chk("rdlat_tid", rsp_tid, 9'h003);
      end
    end
    repeat (6) cyc();

    for (int i = 0; i < vecs.size(); i++) begin
      bw = n_wr; br = n_rsp; bb = n_busy; bq = wlog_addr.size();
      strobe(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].tid);
      repeat (12) cyc();
      chk($sformatf("v%0d_nwr", i), 64'(n_wr - bw), 64'(vecs[i].e_nwr));
      chk($sformatf("v%0d_nrsp", i), 64'(n_rsp - br), 64'(vecs[i].e_nrsp));
      chk($sformatf("v%0d_busy_seen", i), 64'(n_busy != bb), 64'(vecs[i].e_busy));
      chk($sformatf("v%0d_ovf", i), ovf_sticky, vecs[i].e_ovf);
      if (vecs[i].e_nwr == 1 && wlog_addr.size() > bq) begin
        chk($sformatf("v%0d_waddr", i), wlog_addr[bq], vecs[i].e_addr);
        chk($sformatf("v%0d_wdin", i), wlog_din[bq], vecs[i].e_data);
      end
      if (vecs[i].e_nrsp == 1) begin
        chk($sformatf("v%0d_rdata", i), lr_data, vecs[i].e_data);
        chk($sformatf("v%0d_rtid", i), lr_tid, vecs[i].e_tid);
      end
      ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0; cyc();
    end

`ifdef MMIO_BRIDGE_STATS_EN
    stat_clr = 1'b1; cyc(); stat_clr = 1'b0; cyc();
`endif
    // Overflow: the bridge drains one write per 2 cycles while a write arrives every cycle,
    // so the registered count first reaches 8 in cycle 15 and that strobe is dropped even
    // though a pop happens in the same cycle. ovf_clr in that cycle loses to the new drop.
    bq = wlog_addr.size();
    for (int i = 0; i < 16; i++) begin
      mmio_wr_valid = 1'b1; mmio_addr = 16'h0340 + 16'(i); mmio_wdata = 64'(100 + i);
      ovf_clr = (i == 15);
      @(negedge clk);
      if (i == 14) chk("ovf_before_full", ovf_sticky, 0);
      cyc();
    end
    mmio_wr_valid = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_set_wins", ovf_sticky, 1);
    repeat (40) cyc();
    chk("ovf_nwr", 64'(wlog_addr.size() - bq), 64'd15);
    for (int i = 0; i < 15; i++) begin
      if (bq + i < wlog_addr.size()) begin
        chk($sformatf("ovf_w%0d_addr", i), wlog_addr[bq+i], 16'h0340 + 16'(i));
        chk($sformatf("ovf_w%0d_din", i), wlog_din[bq+i], 64'(100 + i));
      end
    end
    chk("ovf_still_set", ovf_sticky, 1);
`ifdef MMIO_BRIDGE_STATS_EN
    chk("stat_wr", stat_wr_cnt, 32'd15);
    chk("stat_rd", stat_rd_cnt, 32'd0);
    chk("stat_drop", stat_drop_cnt, 32'd1);
`endif
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", ovf_sticky, 0);
    cyc();

    // Reset while the RD_LAT=4 instance sits in WAIT_RD (cycles 3..6).
    strobe(0, 1, 16'h0310, 64'h0, 9'h055);
    repeat (3) cyc();
    br4 = n_rsp4;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst4_busy", busy4, 0);
    chk("rst4_rsp_valid", rsp_valid4, 0);
    chk("rst4_tpu_r_w", tpu_r_w4, 0);
    chk("rst4_tpu_addr", tpu_addr4, 0);
    chk("rst4_tpu_din", tpu_din4, 0);
    chk("rst4_rsp_data", rsp_data4, 0);
    chk("rst4_rsp_tid", rsp_tid4, 0);
    chk("rst4_ovf", ovf_sticky4, 0);
    repeat (12) cyc();
    chk("rst4_no_rsp", 64'(n_rsp4 - br4), 64'd0);
    chk("rst4_busy_after", busy4, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
